fir_mac_sequencer: RTL and testbench



---
 rtl/fir_mac_sequencer_if.sv | 53 +++++
 rtl/fir_mac_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_sequencer_if.sv
// rtl/fir_mac_sequencer_if.sv - sample stream, coefficient and MAC bus bundle for fir_mac_sequencer
//
// Optional macro: FIR_SAT_FLAG_EN (adds m_sat and sat_cnt).
// Signals (direction as seen by the master = sequencer):
//   s_valid/s_ready/s_data   in/out/in   16-bit signed input sample stream
//   coef_addr/coef_data      out/in      coefficient ROM lookup (combinational)
//   mac_ce/mac_reload        out         MAC clock enable / accumulator reload
//   mac_a/mac_b              out         MAC sample / coefficient operands
//   mac_p                    in          MAC accumulator, signed PSIZE bits
//   m_valid/m_ready/m_data   out/in/out  16-bit signed output sample stream
//   busy                     out         sequencer not idle
//   m_sat, sat_cnt           out         clip flag and clip counter (FIR_SAT_FLAG_EN)
interface fir_mac_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int PSIZE  = 96
) ();
    logic                     s_valid;
    logic                     s_ready;
    logic signed [15:0]       s_data;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [15:0]       coef_data;
    logic                     mac_ce;
    logic                     mac_reload;
    logic signed [15:0]       mac_a;
    logic signed [15:0]       mac_b;
    logic [PSIZE-1:0]         mac_p;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [15:0]       m_data;
    logic                     busy;
`ifdef FIR_SAT_FLAG_EN
    logic                     m_sat;
    logic [15:0]              sat_cnt;
`endif

    modport master (
        input  s_valid, s_data, coef_data, mac_p, m_ready,
        output s_ready, coef_addr, mac_ce, mac_reload, mac_a, mac_b,
        output m_valid, m_data, busy
`ifdef FIR_SAT_FLAG_EN
        , output m_sat, sat_cnt
`endif
    );

    modport slave (
        output s_valid, s_data, coef_data, mac_p, m_ready,
        input  s_ready, coef_addr, mac_ce, mac_reload, mac_a, mac_b,
        input  m_valid, m_data, busy
`ifdef FIR_SAT_FLAG_EN
        , input m_sat, sat_cnt
`endif
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - sequences an external 16x16 MAC as a TAPS-tap FIR filter
//
// Optional macro: FIR_SAT_FLAG_EN (clip flag m_sat and saturating clip counter sat_cnt).
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset; clears FSM, pointers and the delay line
//   bus  fir_mac_sequencer_if.master: input sample stream, coefficient lookup,
//        MAC drive/result, output sample stream, busy
module fir_mac_sequencer #(
    parameter int TAPS        = 16,
    parameter int ADDR_W      = 4,
    parameter int MAC_LATENCY = 2,
    parameter int FRAC_BITS   = 15,
    parameter int PSIZE       = 96
) (
    input  logic                clk,
    input  logic                rst,
    fir_mac_sequencer_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam int DW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W-1:0] TAPS_A = ADDR_W'(TAPS);
    localparam logic [DW-1:0]     D_LAST = DW'(MAC_LATENCY - 1);
    // Half an LSB of the output; zero when FRAC_BITS is 0.
    localparam logic signed [PSIZE:0] RND   = (PSIZE+1)'((64'd1 << FRAC_BITS) >> 1);
    localparam logic signed [PSIZE:0] MAX_V = (PSIZE+1)'(32767);
    localparam logic signed [PSIZE:0] MIN_V = (PSIZE+1)'(-32768);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  k_q, k_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic               m_valid_q, m_valid_d;
    logic signed [15:0] m_data_q, m_data_d;
    logic signed [15:0] delay_q [TAPS];

    logic [ADDR_W-1:0]  rd_idx;
    logic signed [PSIZE:0] p_ext, p_rnd, p_shr;
    logic               sat_hi, sat_lo;
    logic signed [15:0] result;
    logic               accept, out_hs;

    assign accept = (state_q == S_IDLE) && bus.s_valid;
    assign out_hs = m_valid_q && bus.m_ready;

    // Newest sample first. Subtraction wraps in ADDR_W bits; adding TAPS back
    // on underflow keeps the index inside 0..TAPS-1 for non-power-of-2 TAPS.
    always_comb begin
        if (wr_ptr_q >= k_q) begin
            rd_idx = wr_ptr_q - k_q;
        end else begin
            rd_idx = wr_ptr_q - k_q + TAPS_A;
        end
    end

    // Round half up, arithmetic shift, clip to 16 bits. One guard bit above
    // PSIZE keeps the rounding add from overflowing.
    always_comb begin
        p_ext  = $signed({bus.mac_p[PSIZE-1], bus.mac_p});
        p_rnd  = p_ext + RND;
        p_shr  = p_rnd >>> FRAC_BITS;
        sat_hi = p_shr > MAX_V;
        sat_lo = p_shr < MIN_V;
        if (sat_hi) begin
            result = 16'sh7FFF;
        end else if (sat_lo) begin
            result = -16'sh8000;
        end else begin
            result = p_shr[15:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        k_d       = k_q;
        drain_d   = drain_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.s_valid) begin
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (k_q == K_LAST) begin
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == D_LAST) begin
                    m_data_d  = result;
                    m_valid_d = 1'b1;
                    state_d   = S_OUT;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: begin
                if (out_hs) begin
                    m_valid_d = 1'b0;
                    wr_ptr_d  = (wr_ptr_q == K_LAST) ? '0 : wr_ptr_q + 1'b1;
                    state_d   = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            k_q       <= '0;
            drain_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            k_q       <= k_d;
            drain_q   <= drain_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    // Delay line: a single write per accepted sample, cleared on reset so an
    // aborted run leaves no stale history behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                delay_q[i] <= '0;
            end
        end else if (accept) begin
            delay_q[wr_ptr_q] <= bus.s_data;
        end
    end

`ifdef FIR_SAT_FLAG_EN
    logic        m_sat_q, m_sat_d;
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        m_sat_d   = m_sat_q;
        sat_cnt_d = sat_cnt_q;
        if (state_q == S_DRAIN && drain_q == D_LAST) begin
            m_sat_d = sat_hi || sat_lo;
        end
        if (out_hs && m_sat_q && sat_cnt_q != 16'hFFFF) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sat_q   <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            m_sat_q   <= m_sat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign bus.m_sat   = m_sat_q;
    assign bus.sat_cnt = sat_cnt_q;
`endif

    assign bus.s_ready    = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.mac_ce     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.mac_reload = (state_q == S_RUN) && (k_q == '0);
    assign bus.coef_addr  = (state_q == S_RUN) ? k_q : '0;
    assign bus.mac_a      = (state_q == S_RUN) ? delay_q[rd_idx] : '0;
    assign bus.mac_b      = (state_q == S_RUN) ? bus.coef_data : '0;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - directed self-checking bench for fir_mac_sequencer with a behavioural MAC
module tb_fir_mac_sequencer;
    localparam int TAPS = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.ADDR_W(4), .PSIZE(96)) bus ();

    fir_mac_sequencer #(
        .TAPS(TAPS), .ADDR_W(4), .MAC_LATENCY(2), .FRAC_BITS(15), .PSIZE(96)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic signed [15:0] coef_mem [TAPS];
    assign bus.coef_data = coef_mem[bus.coef_addr];

    // MAC: product pipe register, then accumulator register, both gated by ce.
    logic signed [31:0] prod_w;
    logic signed [95:0] prod_q, acc_q;
    logic               rl_q;
    assign prod_w    = bus.mac_a * bus.mac_b;
    assign bus.mac_p = acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            rl_q   <= 1'b0;
            acc_q  <= '0;
        end else if (bus.mac_ce) begin
            prod_q <= {{64{prod_w[31]}}, prod_w};
            rl_q   <= bus.mac_reload;
            acc_q  <= rl_q ? prod_q : acc_q + prod_q;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_coefs(input int mode);
        for (int i = 0; i < TAPS; i++) begin
            case (mode)
                0:       coef_mem[i] = 16'(i * 256);
                1:       coef_mem[i] = (i == 0) ? 16'sh4000 : 16'sh0000;
                default: coef_mem[i] = 16'sh7FFF;
            endcase
        end
    endtask

    task automatic wait_mvalid(input string tag);
        int t = 0;
        while (bus.m_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_mv"}, {31'd0, bus.m_valid}, 32'd1);
    endtask

    // Feed one sample from IDLE, check the filtered output, handshake it.
    task automatic run_sample(input logic [15:0] x, input logic [15:0] exp, input string tag);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = x;
        @(negedge clk);
        bus.s_valid = 1'b0;
        wait_mvalid(tag);
        chk(tag, {16'd0, bus.m_data}, {16'd0, exp});
        @(negedge clk);
    endtask

    task automatic impulse_run(input string pfx);
        for (int n = 0; n <= TAPS; n++) begin
            run_sample((n == 0) ? 16'h7FFF : 16'h0000,
                       (n < TAPS) ? 16'(n * 256) : 16'h0000,
                       $sformatf("%s%0d", pfx, n));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] v_rl, v_ce, v_mv, v_sr;
        int ok;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        set_coefs(0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mac_ce", {31'd0, bus.mac_ce}, 32'd0);
        chk("rst_reload", {31'd0, bus.mac_reload}, 32'd0);
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_m_data", {16'd0, bus.m_data}, 32'd0);
        chk("rst_coef_addr", {28'd0, bus.coef_addr}, 32'd0);
        chk("rst_mac_a", {16'd0, bus.mac_a}, 32'd0);
        chk("rst_mac_b", {16'd0, bus.mac_b}, 32'd0);

        // Impulse response reads the coefficients back out.
        impulse_run("imp");

        // Rounding with a single 0.5 coefficient.
        set_coefs(1);
        run_sample(16'd3, 16'd2, "rnd_p3");
        run_sample(16'hFFFD, 16'hFFFF, "rnd_m3");
        run_sample(16'd1, 16'd1, "rnd_p1");

        // Cycle-accurate timing of one sample with m_ready held high.
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'd7;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) bus.s_valid = 1'b0;
            v_rl[c-1] = bus.mac_reload;
            v_ce[c-1] = bus.mac_ce;
            v_mv[c-1] = bus.m_valid;
            v_sr[c-1] = bus.s_ready;
        end
        chk("tim_reload", {12'd0, v_rl}, 32'h00001);
        chk("tim_mac_ce", {12'd0, v_ce}, 32'h3FFFF);
        chk("tim_m_valid", {12'd0, v_mv}, 32'h40000);
        chk("tim_s_ready", {12'd0, v_sr}, 32'h80000);

        // Backpressure: 1000 * 0.5 = 500, held for 10 cycles.
        bus.m_ready = 1'b0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'd1000;
        @(negedge clk);
        bus.s_valid = 1'b0;
        wait_mvalid("bp");
        chk("bp_data", {16'd0, bus.m_data}, 32'd500);
        ok = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.m_valid === 1'b1 && bus.m_data === 16'd500 &&
                bus.s_ready === 1'b0 && bus.mac_ce === 1'b0 && bus.busy === 1'b1)
                ok++;
        end
        chk("bp_hold", ok, 32'd10);
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_mv", {31'd0, bus.m_valid}, 32'd0);
        chk("bp_done_sr", {31'd0, bus.s_ready}, 32'd1);

        // Reset in the middle of RUN at k=5, with stale samples in the delay line.
        set_coefs(0);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h1234;
        @(negedge clk);
        bus.s_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_k5", {28'd0, bus.coef_addr}, 32'd5);
        rst = 1'b1;
        #1;
        chk("mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_mac_ce", {31'd0, bus.mac_ce}, 32'd0);
        chk("mid_coef_addr", {28'd0, bus.coef_addr}, 32'd0);
        chk("mid_mac_a", {16'd0, bus.mac_a}, 32'd0);
        @(negedge clk);
        chk("mid_s_ready", {31'd0, bus.s_ready}, 32'd1);
        chk("mid_m_valid", {31'd0, bus.m_valid}, 32'd0);
        rst = 1'b0;
        impulse_run("imp2_");

        // Positive saturation: first output 32766, then clipped.
        set_coefs(2);
        do_reset();
        for (int n = 0; n < TAPS; n++) begin
            run_sample(16'h7FFF, (n == 0) ? 16'h7FFE : 16'h7FFF, $sformatf("satp%0d", n));
        end
`ifdef FIR_SAT_FLAG_EN
        chk("satp_cnt", {16'd0, bus.sat_cnt}, 32'd15);
`endif
        // Negative saturation: first output -32767, then clipped.
        do_reset();
        for (int n = 0; n < TAPS; n++) begin
            run_sample(16'h8000, (n == 0) ? 16'h8001 : 16'h8000, $sformatf("satn%0d", n));
        end
`ifdef FIR_SAT_FLAG_EN
        chk("satn_cnt", {16'd0, bus.sat_cnt}, 32'd15);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
